// File: rtl/interrupt_io_ctrl_pkg.sv
// Shared types and defaults for the interrupt / I/O flag controller.
// State encoding doubles as the int_step value during RT0..RT2.
package interrupt_io_ctrl_pkg;

   typedef enum logic [1:0] {
      RT0  = 2'd0,
      RT1  = 2'd1,
      RT2  = 2'd2,
      IDLE = 2'd3
   } int_state_e;

   localparam int unsigned VEC_ADDR_DEFAULT = 0;

endpackage

// File: rtl/interrupt_io_ctrl_prn_handshake.sv
// Printer side: OUTR, the FGO flag, the valid/ready handshake and the
// sticky overrun flag for an OUT issued while the printer is still busy.
module interrupt_io_ctrl_prn_handshake #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  out_load,
   input  logic [DATA_WIDTH-1:0] ac_low,
   input  logic                  prn_ready,
   output logic [DATA_WIDTH-1:0] outr,
   output logic                  fgo,
   output logic                  prn_valid,
   output logic                  ovr_err
);

   logic [DATA_WIDTH-1:0] outr_q, outr_d;
   logic                  fgo_q, fgo_d;
   logic                  prn_valid_q, prn_valid_d;
   logic                  ovr_err_q, ovr_err_d;

   // FGO=1 implies prn_valid=0, so a load and a printer accept never collide.
   always_comb begin
      outr_d      = outr_q;
      fgo_d       = fgo_q;
      prn_valid_d = prn_valid_q;
      ovr_err_d   = ovr_err_q;
      if (out_load) begin
         if (fgo_q) begin
            outr_d      = ac_low;
            fgo_d       = 1'b0;
            prn_valid_d = 1'b1;
         end else begin
            ovr_err_d = 1'b1;
         end
      end
      if (prn_valid_q && prn_ready) begin
         prn_valid_d = 1'b0;
         fgo_d       = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outr_q      <= '0;
         fgo_q       <= 1'b1;
         prn_valid_q <= 1'b0;
         ovr_err_q   <= 1'b0;
      end else begin
         outr_q      <= outr_d;
         fgo_q       <= fgo_d;
         prn_valid_q <= prn_valid_d;
         ovr_err_q   <= ovr_err_d;
      end
   end

   assign outr      = outr_q;
   assign fgo       = fgo_q;
   assign prn_valid = prn_valid_q;
   assign ovr_err   = ovr_err_q;

endmodule

// File: rtl/interrupt_io_ctrl.sv
// I/O flags, IEN/R flip-flops and the three-step interrupt takeover
// (RT0 capture PC, RT1 store it at VEC_ADDR, RT2 load PC with VEC_ADDR+1).
module interrupt_io_ctrl
   import interrupt_io_ctrl_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 12,
   parameter logic [ADDR_WIDTH-1:0] VEC_ADDR   = ADDR_WIDTH'(VEC_ADDR_DEFAULT)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  kbd_valid,
   input  logic [DATA_WIDTH-1:0] kbd_data,
   output logic                  kbd_ready,
   output logic                  prn_valid,
   output logic [DATA_WIDTH-1:0] prn_data,
   input  logic                  prn_ready,
   input  logic                  inp_ack,
   input  logic                  out_load,
   input  logic [DATA_WIDTH-1:0] ac_low,
   input  logic                  set_ien,
   input  logic                  clr_ien,
   input  logic                  instr_boundary,
   input  logic [ADDR_WIDTH-1:0] pc_in,
   output logic [DATA_WIDTH-1:0] INPR,
   output logic                  FGI,
   output logic                  FGO,
   output logic                  IEN,
   output logic                  R,
   output logic                  int_cycle,
   output logic [1:0]            int_step,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [ADDR_WIDTH-1:0] mem_wdata,
   output logic                  mem_write,
   output logic                  pc_load,
   output logic                  ovr_err
);

   int_state_e            state_q, state_d;
   logic                  fgi_q, fgi_d;
   logic                  ien_q, ien_d;
   logic                  r_q, r_d;
   logic [DATA_WIDTH-1:0] inpr_q, inpr_d;
   logic [ADDR_WIDTH-1:0] save_pc_q, save_pc_d;
   logic                  fgo;
   logic                  in_cycle;
   logic [1:0]            state_bits;

   assign in_cycle   = (state_q != IDLE);
   assign state_bits = state_q;

   interrupt_io_ctrl_prn_handshake #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_prn (
      .clk       (CLK),
      .rst       (RST),
      .out_load  (out_load),
      .ac_low    (ac_low),
      .prn_ready (prn_ready),
      .outr      (prn_data),
      .fgo       (fgo),
      .prn_valid (prn_valid),
      .ovr_err   (ovr_err)
   );

   always_comb begin
      fgi_d  = fgi_q;
      inpr_d = inpr_q;
      if (kbd_valid && !fgi_q) begin
         inpr_d = kbd_data;
         fgi_d  = 1'b1;
      end else if (inp_ack && fgi_q) begin
         fgi_d = 1'b0;
      end

      // The control unit's ION/IOF are locked out for the whole takeover.
      ien_d = ien_q;
      if (state_q == RT2) begin
         ien_d = 1'b0;
      end else if (!in_cycle) begin
         if (clr_ien) begin
            ien_d = 1'b0;
         end else if (set_ien) begin
            ien_d = 1'b1;
         end
      end

      r_d = r_q;
      if (state_q == RT2) begin
         r_d = 1'b0;
      end else if ((state_q == IDLE) && ien_q && (fgi_q || fgo)) begin
         r_d = 1'b1;
      end

      save_pc_d = (state_q == RT0) ? pc_in : save_pc_q;

      // Entry looks at the registered R, so a same-edge R set waits a boundary.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (r_q && instr_boundary) state_d = RT0;
         RT0:     state_d = RT1;
         RT1:     state_d = RT2;
         RT2:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         fgi_q     <= 1'b0;
         ien_q     <= 1'b0;
         r_q       <= 1'b0;
         inpr_q    <= '0;
         save_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         fgi_q     <= fgi_d;
         ien_q     <= ien_d;
         r_q       <= r_d;
         inpr_q    <= inpr_d;
         save_pc_q <= save_pc_d;
      end
   end

   assign kbd_ready = !fgi_q;
   assign INPR      = inpr_q;
   assign FGI       = fgi_q;
   assign FGO       = fgo;
   assign IEN       = ien_q;
   assign R         = r_q;
   assign int_cycle = in_cycle;
   assign int_step  = in_cycle ? state_bits : 2'd0;
   assign mem_write = (state_q == RT1);
   assign pc_load   = (state_q == RT2);
   assign mem_addr  = mem_write ? VEC_ADDR : '0;
   assign mem_wdata = mem_write ? save_pc_q : '0;

endmodule

// File: tb/tb_interrupt_io_ctrl.sv
// Scoreboard bench: stimulus pushes expected snapshots / strobes, monitors
// pop and compare at the falling edge (or on demand mid-cycle).
module tb_interrupt_io_ctrl;

   localparam int DW = 8;
   localparam int AW = 12;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          kbd_valid = 1'b0;
   logic [DW-1:0] kbd_data = '0;
   logic          kbd_ready;
   logic          prn_valid;
   logic [DW-1:0] prn_data;
   logic          prn_ready = 1'b0;
   logic          inp_ack = 1'b0;
   logic          out_load = 1'b0;
   logic [DW-1:0] ac_low = '0;
   logic          set_ien = 1'b0;
   logic          clr_ien = 1'b0;
   logic          instr_boundary = 1'b0;
   logic [AW-1:0] pc_in = '0;
   logic [DW-1:0] INPR;
   logic          FGI, FGO, IEN, R;
   logic          int_cycle;
   logic [1:0]    int_step;
   logic [AW-1:0] mem_addr, mem_wdata;
   logic          mem_write, pc_load, ovr_err;

   interrupt_io_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .VEC_ADDR   (12'h000)
   ) dut (
      .CLK            (CLK),
      .RST            (RST),
      .kbd_valid      (kbd_valid),
      .kbd_data       (kbd_data),
      .kbd_ready      (kbd_ready),
      .prn_valid      (prn_valid),
      .prn_data       (prn_data),
      .prn_ready      (prn_ready),
      .inp_ack        (inp_ack),
      .out_load       (out_load),
      .ac_low         (ac_low),
      .set_ien        (set_ien),
      .clr_ien        (clr_ien),
      .instr_boundary (instr_boundary),
      .pc_in          (pc_in),
      .INPR           (INPR),
      .FGI            (FGI),
      .FGO            (FGO),
      .IEN            (IEN),
      .R              (R),
      .int_cycle      (int_cycle),
      .int_step       (int_step),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_write      (mem_write),
      .pc_load        (pc_load),
      .ovr_err        (ovr_err)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic          fgi, fgo, ien, r, kbd_ready, prn_valid;
      logic [DW-1:0] prn_data, inpr;
      logic          ovr_err, int_cycle;
      logic [1:0]    int_step;
      logic          mem_write, pc_load;
   } snap_t;

   typedef struct packed {
      logic          mem_write, pc_load;
      logic [AW-1:0] addr, wdata;
   } strobe_t;

   typedef struct {
      string name;
      snap_t s;
   } exp_t;

   exp_t    snap_q[$];
   strobe_t strobe_q[$];
   int      checks = 0;
   int      errors = 0;
   event    check_ev;
   snap_t   e;

   // Monitor: compares queued snapshots and any strobe the DUT presents.
   initial begin
      exp_t    x;
      snap_t   a;
      strobe_t sa, sx;
      forever begin
         @(negedge CLK or check_ev);
         while (snap_q.size() > 0) begin
            x = snap_q.pop_front();
            a = '{FGI, FGO, IEN, R, kbd_ready, prn_valid, prn_data, INPR,
                  ovr_err, int_cycle, int_step, mem_write, pc_load};
            checks++;
            if (a !== x.s) begin
               errors++;
               $display("FAIL %s: got %h want %h (fgi fgo ien r rdy pv data inpr ovr ic step mw pl)",
                        x.name, a, x.s);
            end
         end
         if (mem_write || pc_load) begin
            sa = '{mem_write, pc_load, mem_addr, mem_wdata};
            checks++;
            if (strobe_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_strobe: got %h want none", sa);
            end else begin
               sx = strobe_q.pop_front();
               if (sa !== sx) begin
                  errors++;
                  $display("FAIL strobe: got %h want %h", sa, sx);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_snap(input string n);
      exp_t x;
      x.name = n;
      x.s    = e;
      snap_q.push_back(x);
      $display("txn %s: expect %h", n, e);
   endtask

   task automatic expect_strobe(input logic mw, input logic pl,
                                input logic [AW-1:0] ad, input logic [AW-1:0] wd);
      strobe_t s;
      s = '{mw, pl, ad, wd};
      strobe_q.push_back(s);
   endtask

   function automatic snap_t reset_snap();
      snap_t s;
      s           = '0;
      s.fgo       = 1'b1;
      s.kbd_ready = 1'b1;
      return s;
   endfunction

   initial begin
      tick();
      tick();
      RST = 1'b0;
      e = reset_snap();
      expect_snap("reset");

      // Keyboard handshake, blocked second char, INP ack
      kbd_valid = 1'b1; kbd_data = 8'h41; tick(); kbd_valid = 1'b0;
      e.fgi = 1'b1; e.inpr = 8'h41; e.kbd_ready = 1'b0;
      expect_snap("kbd_load");
      kbd_valid = 1'b1; kbd_data = 8'h99; tick(); kbd_valid = 1'b0;
      expect_snap("kbd_blocked");
      inp_ack = 1'b1; tick();
      e.fgi = 1'b0; e.kbd_ready = 1'b1;
      expect_snap("inp_ack");
      tick(); inp_ack = 1'b0;
      expect_snap("inp_ack_idle");

      // Printer load, overrun, accept
      out_load = 1'b1; ac_low = 8'h5A; tick(); out_load = 1'b0;
      e.prn_valid = 1'b1; e.prn_data = 8'h5A; e.fgo = 1'b0;
      expect_snap("out_load");
      out_load = 1'b1; ac_low = 8'h33; tick(); out_load = 1'b0;
      e.ovr_err = 1'b1;
      expect_snap("out_overrun");
      prn_ready = 1'b1; tick(); prn_ready = 1'b0;
      e.prn_valid = 1'b0; e.fgo = 1'b1;
      expect_snap("prn_accept");

      // IEN=0: boundaries with FGO=1 must not raise R
      instr_boundary = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_snap("ien_off_boundary");
      end
      instr_boundary = 1'b0;
      set_ien = 1'b1; clr_ien = 1'b1; tick(); set_ien = 1'b0; clr_ien = 1'b0;
      expect_snap("clr_beats_set");

      // Full interrupt cycle
      pc_in = 12'h123;
      set_ien = 1'b1; kbd_valid = 1'b1; kbd_data = 8'h7E; tick();
      set_ien = 1'b0; kbd_valid = 1'b0;
      e.ien = 1'b1; e.fgi = 1'b1; e.inpr = 8'h7E; e.kbd_ready = 1'b0;
      expect_snap("ion");
      instr_boundary = 1'b1; tick();
      e.r = 1'b1;
      expect_snap("r_set_no_entry");
      tick(); instr_boundary = 1'b0; clr_ien = 1'b1;
      e.int_cycle = 1'b1; e.int_step = 2'd0;
      expect_snap("rt0");
      tick(); clr_ien = 1'b0; inp_ack = 1'b1;
      e.int_step = 2'd1; e.mem_write = 1'b1;
      expect_snap("rt1");
      expect_strobe(1'b1, 1'b0, 12'h000, 12'h123);
      tick(); inp_ack = 1'b0; set_ien = 1'b1;
      e.int_step = 2'd2; e.mem_write = 1'b0; e.pc_load = 1'b1;
      e.fgi = 1'b0; e.kbd_ready = 1'b1;
      expect_snap("rt2");
      expect_strobe(1'b0, 1'b1, 12'h000, 12'h000);
      tick(); set_ien = 1'b0;
      e.int_cycle = 1'b0; e.int_step = 2'd0; e.pc_load = 1'b0;
      e.ien = 1'b0; e.r = 1'b0;
      expect_snap("exit_idle");
      tick();
      expect_snap("post_exit");

      // Second interrupt, reset during RT1
      pc_in = 12'h456;
      set_ien = 1'b1; tick(); set_ien = 1'b0;
      e.ien = 1'b1;
      expect_snap("ion2");
      tick();
      e.r = 1'b1;
      expect_snap("r_set2");
      instr_boundary = 1'b1; tick(); instr_boundary = 1'b0;
      e.int_cycle = 1'b1; e.int_step = 2'd0;
      expect_snap("rt0_2");
      tick();
      e.int_step = 2'd1; e.mem_write = 1'b1;
      expect_snap("rt1_2");
      expect_strobe(1'b1, 1'b0, 12'h000, 12'h456);
      @(negedge CLK);
      #2;
      RST = 1'b1;
      #1;
      e = reset_snap();
      expect_snap("rst_mid_rt1");
      -> check_ev;
      tick();
      RST = 1'b0;
      expect_snap("rst_held");
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_snap("after_rst");
      end

      @(negedge CLK);
      #1;
      checks++;
      if (strobe_q.size() != 0) begin
         errors++;
         $display("FAIL strobes_missing: got %0d pending want 0", strobe_q.size());
      end
      checks++;
      if (snap_q.size() != 0) begin
         errors++;
         $display("FAIL snaps_pending: got %0d pending want 0", snap_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/interrupt_io_ctrl.md
Name: interrupt_io_ctrl

Overview:
- Owns the I/O flags (FGI, FGO), the interrupt-enable flip-flop (IEN) and the interrupt request flip-flop (R) for the basic-computer datapath.
- Performs valid/ready handshakes with one keyboard and one printer, and loads INPR and OUTR.
- At an instruction boundary with an interrupt pending, takes over from the control unit for three steps (RT0–RT2): saves PC at the vector address and redirects PC to VEC_ADDR+1.

Parameters:
- DATA_WIDTH, 8: character width of INPR, OUTR, kbd_data and prn_data.
- ADDR_WIDTH, 12: width of PC and memory address.
- VEC_ADDR, 0: memory address where the return PC is saved.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- kbd_valid  in  1  keyboard has a character.
- kbd_data  in  DATA_WIDTH  keyboard character.
- kbd_ready  out  1  INPR is free; equals !FGI.
- prn_valid  out  1  OUTR holds a character for the printer.
- prn_data  out  DATA_WIDTH  OUTR contents.
- prn_ready  in  1  printer accepts the character.
- inp_ack  in  1  pulse from the control unit when INP executes (clears FGI).
- out_load  in  1  pulse from the control unit when OUT executes.
- ac_low  in  DATA_WIDTH  AC(7:0), the data for OUT.
- set_ien  in  1  ION pulse from the control unit.
- clr_ien  in  1  IOF pulse from the control unit.
- instr_boundary  in  1  control unit is clearing SC (last T step of an instruction).
- pc_in  in  ADDR_WIDTH  current PC.
- INPR  out  DATA_WIDTH  input register.
- FGI, FGO, IEN, R  out  1 each  flag flip-flops.
- int_cycle  out  1  high during RT0–RT2; the control unit suppresses fetch while it is high.
- int_step  out  2  0=RT0, 1=RT1, 2=RT2 (0 when idle).
- mem_addr  out  ADDR_WIDTH  VEC_ADDR during RT1, else 0.
- mem_wdata  out  ADDR_WIDTH  saved return PC during RT1, else 0.
- mem_write, pc_load  out  1 each  datapath strobes.
- ovr_err  out  1  sticky OUT-overrun flag.

Behaviour:
- Reset (asynchronous, takes effect immediately, any state):
  - FGI=0, FGO=1, IEN=0, R=0, INPR=0, OUTR=0, prn_valid=0, ovr_err=0.
  - FSM=IDLE; all strobes 0.
  - An interrupt cycle in progress is abandoned with no further strobes.
- Keyboard:
  - kbd_ready=!FGI.
  - On an edge where kbd_valid && kbd_ready: INPR<=kbd_data, FGI<=1.
  - inp_ack with FGI=1: FGI<=0 next edge. inp_ack with FGI=0 is ignored.
  - inp_ack and the handshake cannot coincide, because ready is 0 whenever FGI=1.
- Printer:
  - out_load with FGO=1: OUTR<=ac_low, FGO<=0, prn_valid<=1.
  - prn_valid stays high until an edge with prn_ready; on that edge prn_valid<=0 and FGO<=1.
  - out_load with FGO=0: OUTR is unchanged and ovr_err<=1.
  - prn_data=OUTR at all times.
- IEN:
  - clr_ien has priority over set_ien.
  - Both are ignored while int_cycle=1.
  - IEN<=0 on the RT2 edge; the RT2 clear wins over any same-edge set.
- R:
  - R<=1 on any edge with FSM=IDLE && IEN && (FGI||FGO).
  - Once set, R holds until RT2, even if the flags clear.
- FSM: IDLE → RT0 → RT1 → RT2 → IDLE.
  - IDLE→RT0 on an edge with R=1 && instr_boundary=1.
  - R becoming 1 on the same edge as instr_boundary does not qualify; entry waits for the next boundary.
  - RT0: int_cycle=1. Captures save_pc<=pc_in. The control unit clears AR and loads TR in the same step.
  - RT1: mem_write=1, mem_addr=VEC_ADDR, mem_wdata=save_pc.
  - RT2: pc_load=1 with PC value VEC_ADDR+1, which the control unit muxes in. On exit: R<=0, IEN<=0.
  - Latency: exactly 3 cycles from entry to IDLE.
- Strobes:
  - mem_write and pc_load are combinational decodes of FSM state, never registered.
  - Each is high for exactly one cycle per interrupt.
- Width rules: VEC_ADDR+1 is computed modulo 2^ADDR_WIDTH, so VEC_ADDR=all-ones wraps to 0.
- Interaction with I/O during an interrupt cycle: the flag handshakes keep running during RT0–RT2.

Decomposition:
- Shared package:
  - FSM state enum {IDLE, RT0, RT1, RT2} with 2-bit encoding equal to int_step.
  - Default constant VEC_ADDR.
- Sub-module prn_handshake: OUTR, FGO, prn_valid and ovr_err logic, instantiated once.
- Everything else stays inline.

Test Plan:
- Reset release → FGO=1, FGI=0, IEN=0, kbd_ready=1, int_cycle=0.
- Keyboard handshake and INP:
  - kbd_valid=1, kbd_data=8'h41 → INPR=8'h41, FGI=1, kbd_ready=0.
  - inp_ack pulse → FGI=0.
  - Second kbd_valid while FGI=1 → INPR stays 8'h41.
- Printer handshake and overrun:
  - out_load with ac_low=8'h5A → prn_valid=1, prn_data=8'h5A, FGO=0.
  - Second out_load before prn_ready → ovr_err=1, prn_data=8'h5A.
  - prn_ready → FGO=1, prn_valid=0.
- Interrupt cycle (VEC_ADDR=0):
  - set_ien, FGI=1, pc_in=12'h123, instr_boundary → R=1, then RT0.
  - RT1: mem_write=1, mem_addr=0, mem_wdata=12'h123.
  - RT2: pc_load=1.
  - Afterwards: IEN=0, R=0, IDLE.
- IEN=0 with FGO=1 and repeated instr_boundary → R stays 0, int_cycle never asserts.
- Reset mid-cycle: RST asserted during RT1 → mem_write drops immediately, FSM=IDLE, R=0; no RT2 strobe after release.
